// File: rtl/mul_issue_queue.sv
// mul_issue_queue
//
// Credit-based issue wrapper around a fixed-latency, non-stallable DSP
// multiplier. Operand pairs arrive over a ready/valid request port. They are
// registered onto the multiplier inputs, and every product is captured into
// a result FIFO. Products are returned in order over a ready/valid response
// port.
//
// The multiplier cannot be stalled, so a request is admitted only while a
// FIFO slot is guaranteed for its result. The outstanding counter holds the
// requests accepted but not yet popped, and it never exceeds DEPTH.
//
// Parameters:
//   W       operand/product width (products truncated to W bits)
//   LATENCY multiplier latency, mul_valid_in -> mul_valid_out
//   DEPTH   result FIFO entries and credit limit (>= 2)
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_in0/req_in1       request operands
//   mul_in0/mul_in1       registered operands to the multiplier
//   mul_valid_in          registered one-cycle issue strobe
//   mul_out/mul_valid_out product and result strobe from the multiplier
//   rsp_valid/rsp_ready   response handshake (FIFO head)
//   rsp_data              FIFO head product
//   latency_error         sticky latency-mismatch flag
//
// Optional feature:
//   MUL_ISSUE_LATENCY_CHECK_EN - when defined, a shadow shift register of
//   the issue strobe is compared with mul_valid_out every cycle. Any
//   mismatch sets latency_error until reset. When undefined,
//   latency_error is tied to 0.

module mul_issue_queue #(
  parameter int W       = 16,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_in0,
  input  logic [W-1:0] req_in1,
  output logic [W-1:0] mul_in0,
  output logic [W-1:0] mul_in1,
  output logic         mul_valid_in,
  input  logic [W-1:0] mul_out,
  input  logic         mul_valid_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         latency_error
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int INF_W = $clog2(LATENCY + 2);

  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [INF_W-1:0] inflight;
  logic [W-1:0]     mem [DEPTH];

  logic accept;
  logic pop;
  logic capture;
  logic fifo_full;
  logic fifo_write;

  // Handshakes. req_ready depends only on the credit counter, so there is
  // no combinational path from rsp_ready or req_valid to req_ready.
  assign req_ready = (outstanding < CNT_W'(DEPTH));
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;

  // A strobe with nothing in flight is a leftover from before reset. It is
  // dropped so that it never reaches the FIFO.
  assign capture    = mul_valid_out & (inflight != '0);
  assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
  // Credits make a write into a full FIFO unreachable unless a pop frees
  // the slot in the same cycle. Such a write is ignored for safety.
  assign fifo_write = capture & (~fifo_full | pop);

  // The head is read from registered storage. A fresh write becomes
  // visible only in the following cycle, so there is no bypass.
  assign rsp_data = mem[rd_ptr];

  // Credit counter: accepted requests not yet popped. When a pop and an
  // accept happen in the same cycle, the count is unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= '0;
    end else if (accept && !pop) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!accept && pop) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  // Issue register. When no request is accepted, the operands are zeroed,
  // so the DSP never sees stale data with a low strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      mul_valid_in <= 1'b0;
      mul_in0      <= '0;
      mul_in1      <= '0;
    end else begin
      mul_valid_in <= accept;
      mul_in0      <= accept ? req_in0 : '0;
      mul_in1      <= accept ? req_in1 : '0;
    end
  end

  // Operations issued to the multiplier but not yet captured.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight <= '0;
    end else if (mul_valid_in && !capture) begin
      inflight <= inflight + INF_W'(1);
    end else if (!mul_valid_in && capture) begin
      inflight <= inflight - INF_W'(1);
    end
  end

  // Result FIFO: circular buffer. The pointers wrap modulo DEPTH, so
  // DEPTH does not need to be a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (fifo_write) begin
        mem[wr_ptr] <= mul_out;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (fifo_write && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (!fifo_write && pop) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

`ifdef MUL_ISSUE_LATENCY_CHECK_EN
  localparam int MSK_W = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] shadow;
  logic [MSK_W-1:0]   mask_cnt;
  logic               lat_err;

  // The top bit of the shadow register predicts mul_valid_out for the
  // current cycle. For LATENCY cycles after reset the compare is masked,
  // because the DSP may still emit results issued before reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow   <= '0;
      mask_cnt <= '0;
      lat_err  <= 1'b0;
    end else begin
      shadow <= (shadow << 1) | LATENCY'(mul_valid_in);
      if (mask_cnt != MSK_W'(LATENCY)) begin
        mask_cnt <= mask_cnt + MSK_W'(1);
      end
      if ((mask_cnt == MSK_W'(LATENCY)) && (shadow[LATENCY-1] != mul_valid_out)) begin
        lat_err <= 1'b1;
      end
    end
  end

  assign latency_error = lat_err;
`else
  assign latency_error = 1'b0;
`endif

endmodule

// File: tb/tb_mul_issue_queue.sv
// tb_mul_issue_queue
//
// Directed and random stimulus for mul_issue_queue, with a behavioural stub
// of the DSP multiplier (latency selectable, not reset). The reference model
// is a queue of expected products, each tagged with the cycle at which it
// should reach the FIFO head. It also keeps a credit count for the expected
// req_ready.

module tb_mul_issue_queue;

  localparam int W       = 16;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_in0;
  logic [W-1:0] req_in1;
  logic [W-1:0] mul_in0;
  logic [W-1:0] mul_in1;
  logic         mul_valid_in;
  logic [W-1:0] mul_out;
  logic         mul_valid_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         latency_error;

  always #5 clock = ~clock;

  mul_issue_queue #(.W(W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_in0       (req_in0),
    .req_in1       (req_in1),
    .mul_in0       (mul_in0),
    .mul_in1       (mul_in1),
    .mul_valid_in  (mul_valid_in),
    .mul_out       (mul_out),
    .mul_valid_out (mul_valid_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .latency_error (latency_error)
  );

  // Stub DSP: a plain shift pipeline that ignores reset, like the real one.
  logic         pipe_v [0:3];
  logic [W-1:0] pipe_d [0:3];
  int           stub_lat = LATENCY;

  always @(posedge clock) begin
    pipe_v[0] <= mul_valid_in;
    pipe_d[0] <= mul_in0 * mul_in1;
    for (int i = 1; i < 4; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign mul_valid_out = pipe_v[stub_lat-1];
  assign mul_out       = pipe_d[stub_lat-1];

  // Reference model state
  typedef struct {
    logic [W-1:0] prod;
    int           due;
  } exp_t;

  exp_t         q[$];
  int           out_cnt = 0;
  bit           last_acc = 0;
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;
  int           cyc = 0;
  bit           model_on = 0;

  // Observation bookkeeping
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] got[$];
  int           rsp_cnt = 0;
  int           first_rsp_cyc = -1;
  int           run = 0;
  int           best_run = 0;
  int           acc_obs = 0;
  int           stall_obs = 0;
  logic         last_lat = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] product(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] full;
    full = 32'(a) * 32'(b);
    return full[W-1:0];
  endfunction

  // One clock cycle: compare the outputs with the model at the falling
  // edge, advance the model with the current inputs, then step past the
  // rising edge.
  task automatic tick();
    bit   exp_ready;
    bit   exp_valid;
    bit   acc;
    bit   pop;
    exp_t e;
    @(negedge clock);
    exp_ready = (out_cnt < DEPTH);
    exp_valid = (q.size() > 0) && (q[0].due <= cyc);
    if (model_on) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (exp_valid) check("rsp_data", 32'(rsp_data), 32'(q[0].prod));
      check("mul_valid_in", 32'(mul_valid_in), 32'(last_acc));
      check("mul_in0", 32'(mul_in0), 32'(last_a));
      check("mul_in1", 32'(mul_in1), 32'(last_b));
      check("latency_error", 32'(latency_error), 32'd0);
    end
    last_lat = latency_error;
    if (rsp_valid) begin
      if (rsp_cnt == 0) first_rsp_cyc = cyc;
      rsp_cnt++;
      run++;
      if (run > best_run) best_run = run;
    end else begin
      run = 0;
    end
    if (rsp_valid && rsp_ready) got.push_back(rsp_data);
    if (req_valid && req_ready) acc_obs++;
    if (req_valid && !req_ready) stall_obs++;
    acc = req_valid && exp_ready;
    pop = exp_valid && rsp_ready;
    if (reset) begin
      q.delete();
      out_cnt  = 0;
      last_acc = 0;
      last_a   = '0;
      last_b   = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.prod = product(req_in0, req_in1);
        e.due  = cyc + LATENCY + 2;
        q.push_back(e);
      end
      out_cnt  = out_cnt + int'(acc) - int'(pop);
      last_acc = acc;
      last_a   = acc ? req_in0 : '0;
      last_b   = acc ? req_in1 : '0;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic apply_stimulus(input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = v;
    req_in0   = a;
    req_in1   = b;
  endtask

  initial begin
    int           start;
    int           nbad;
    logic [W-1:0] sexp[$];
    logic         lat_k [0:8];

    reset = 1'b1;
    rsp_ready = 1'b0;
    apply_stimulus(0, '0, '0);
    tick();
    model_on = 1;
    tick();
    reset = 1'b0;

    $display("[TB] reset values");
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_mul_valid_in", 32'(mul_valid_in), 32'd0);
    check("rst_mul_in0", 32'(mul_in0), 32'd0);
    check("rst_mul_in1", 32'(mul_in1), 32'd0);
    check("rst_latency_error", 32'(latency_error), 32'd0);

    $display("[TB] single op 3 x 7");
    rsp_ready = 1'b1;
    got.delete();
    rsp_cnt = 0;
    start = cyc;
    apply_stimulus(1, 16'd3, 16'd7);
    tick();
    apply_stimulus(0, '0, '0);
    repeat (8) tick();
    check("single_rsp_cycles", 32'(rsp_cnt), 32'd1);
    check("single_latency", 32'(first_rsp_cyc - start), 32'd4);
    check("single_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("single_data", 32'(got[0]), 32'd21);

    $display("[TB] streaming 50 ops");
    got.delete();
    sexp.delete();
    best_run = 0;
    acc_obs = 0;
    stall_obs = 0;
    for (int i = 0; i < 50; i++) begin
      apply_stimulus(1, W'($urandom_range(10, 1)), W'($urandom_range(10, 1)));
      sexp.push_back(product(req_in0, req_in1));
      tick();
    end
    apply_stimulus(0, '0, '0);
    repeat (8) tick();
    check("stream_accepts", 32'(acc_obs), 32'd50);
    check("stream_stalls", 32'(stall_obs), 32'd0);
    check("stream_valid_run", 32'(best_run), 32'd50);
    check("stream_count", 32'(got.size()), 32'd50);
    nbad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i >= got.size() || got[i] !== sexp[i]) nbad++;
    end
    check("stream_order", 32'(nbad), 32'd0);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    acc_obs = 0;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1, W'($urandom), W'($urandom));
      tick();
    end
    check("bp_accepts", 32'(acc_obs), 32'(DEPTH));
    check("bp_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    apply_stimulus(0, '0, '0);
    check("bp_ready_after_pop", 32'(req_ready), 32'd1);
    tick();
    rsp_ready = 1'b1;
    repeat (12) tick();

    $display("[TB] truncation");
    got.delete();
    apply_stimulus(1, 16'hFFFF, 16'h0002);
    tick();
    apply_stimulus(1, 16'h0100, 16'h0100);
    tick();
    apply_stimulus(0, '0, '0);
    repeat (8) tick();
    check("trunc_count", 32'(got.size()), 32'd2);
    if (got.size() > 1) begin
      check("trunc_ffff_x2", 32'(got[0]), 32'h0000FFFE);
      check("trunc_100_x100", 32'(got[1]), 32'h00000000);
    end

    $display("[TB] reset mid-flight");
    apply_stimulus(1, 16'd6, 16'd7);
    tick();
    apply_stimulus(1, 16'd8, 16'd9);
    tick();
    apply_stimulus(0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp_cnt = 0;
    repeat (10) tick();
    check("midrst_no_rsp", 32'(rsp_cnt), 32'd0);
    got.delete();
    apply_stimulus(1, 16'd4, 16'd5);
    tick();
    apply_stimulus(0, '0, '0);
    repeat (8) tick();
    check("midrst_fresh_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("midrst_fresh_data", 32'(got[0]), 32'd20);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(($urandom % 4) != 0, W'($urandom), W'($urandom));
      rsp_ready = ($urandom % 3) != 0;
      tick();
    end
    apply_stimulus(0, '0, '0);
    rsp_ready = 1'b1;
    repeat (12) tick();
    check("random_drained", 32'(rsp_valid), 32'd0);

`ifdef MUL_ISSUE_LATENCY_CHECK_EN
    $display("[TB] latency check with a 3-cycle multiplier");
    model_on = 0;
    stub_lat = 3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    apply_stimulus(1, 16'd2, 16'd3);
    tick();
    apply_stimulus(0, '0, '0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      lat_k[k] = last_lat;
    end
    check("laterr_before", 32'(lat_k[3]), 32'd0);
    check("laterr_set", 32'(lat_k[4]), 32'd1);
    check("laterr_sticky", 32'(lat_k[8]), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("laterr_cleared", 32'(last_lat), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
